// File: rtl/spi_flash_seq_pkg.sv
// Shared definitions for the SPI flash command sequencer: flash opcodes and FSM state encoding.
package spi_flash_seq_pkg;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_SE   = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPCODE,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_END,
        ST_WIP_CMD,
        ST_WIP_READ
    } state_e;

endpackage

// File: rtl/spi_flash_seq_rd_skid.sv
// One-entry read buffer between the serializer and the application; a load wins over a drain.
module spi_flash_seq_rd_skid (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       load,
    input  logic [7:0] in_data,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       full
);

    logic       valid_q;
    logic [7:0] data_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= in_data;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign full      = valid_q;

endmodule

// File: rtl/spi_flash_seq.sv
// SPI flash command sequencer: opcode + address + data phase as one csn-low bitstream.
// Build option SPI_FLASH_WIP_POLL_EN adds automatic RDSR polling after write commands.
//
// state    | meaning
// IDLE     | waiting for a command
// OPCODE   | sending the opcode byte
// ADDR     | sending address bytes, MSB first
// WDATA    | streaming application write bytes to the serializer
// RDATA    | clocking in read bytes into the read buffer
// END      | spi_en_o low, waiting for all bytes, empty buffer and csn high
// WIP_CMD  | sending RDSR
// WIP_READ | reading status until WIP clears
module spi_flash_seq
    import spi_flash_seq_pkg::*;
#(
    parameter int ADDR_BYTES = 3,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [7:0]              cmd_op_i,
    input  logic                    cmd_addr_en_i,
    input  logic [8*ADDR_BYTES-1:0] cmd_addr_i,
    input  logic                    cmd_dir_i,
    input  logic [LEN_WIDTH-1:0]    cmd_len_i,
    input  logic [7:0]              wr_data_i,
    input  logic                    wr_valid_i,
    output logic                    wr_ready_o,
    output logic [7:0]              rd_data_o,
    output logic                    rd_valid_o,
    input  logic                    rd_ready_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    spi_en_o,
    output logic [7:0]              spi_wr_data_o,
    output logic                    spi_wr_valid_o,
    input  logic                    spi_wr_ready_i,
    input  logic [7:0]              spi_rd_data_i,
    input  logic                    spi_rd_valid_i,
    output logic                    spi_rd_ready_o,
    input  logic                    spi_csn_i
);

    localparam int CW = LEN_WIDTH + 3;

    state_e                  state_q, state_d, data_st;
    logic [7:0]              op_q;
    logic [8*ADDR_BYTES-1:0] addr_q;
    logic                    addr_en_q, dir_q;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [CW-1:0]           total_q, total_d, done_cnt_q, done_cnt_d, rem_q, rem_d, hdr;
    logic [1:0]              idx_q, idx_d;
    logic                    accept, addr_step, buf_load, buf_full;
`ifdef SPI_FLASH_WIP_POLL_EN
    logic                    wip_q, wip_d;
`endif

    assign accept = cmd_valid_i && cmd_ready_o;
    assign busy_o = (state_q != ST_IDLE);
    // Bytes before the data phase; their rx pulses never reach the read buffer.
    assign hdr    = CW'(1) + (addr_en_q ? CW'(ADDR_BYTES) : '0);

    always_comb begin
        state_d        = state_q;
        total_d        = total_q;
        done_cnt_d     = done_cnt_q;
        rem_d          = rem_q;
        idx_d          = idx_q;
        addr_step      = 1'b0;
        buf_load       = 1'b0;
        cmd_ready_o    = 1'b0;
        wr_ready_o     = 1'b0;
        done_o         = 1'b0;
        spi_en_o       = 1'b0;
        spi_wr_data_o  = 8'h00;
        spi_wr_valid_o = 1'b0;
        spi_rd_ready_o = 1'b0;
`ifdef SPI_FLASH_WIP_POLL_EN
        wip_d          = wip_q;
`endif
        data_st = (len_q == '0) ? ST_END : (dir_q ? ST_WDATA : ST_RDATA);

        if (spi_rd_valid_i && state_q != ST_IDLE)
            done_cnt_d = done_cnt_q + CW'(1);

        case (state_q)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    state_d    = ST_OPCODE;
                    total_d    = CW'(1) + (cmd_addr_en_i ? CW'(ADDR_BYTES) : '0) + CW'(cmd_len_i);
                    done_cnt_d = '0;
                    idx_d      = '0;
`ifdef SPI_FLASH_WIP_POLL_EN
                    wip_d      = 1'b0;
`endif
                end
            end
            ST_OPCODE: begin
                spi_en_o       = 1'b1;
                spi_wr_valid_o = 1'b1;
                spi_wr_data_o  = op_q;
                if (spi_wr_ready_i) begin
                    state_d = addr_en_q ? ST_ADDR : data_st;
                    rem_d   = CW'(len_q);
                end
            end
            ST_ADDR: begin
                spi_en_o       = 1'b1;
                spi_wr_valid_o = 1'b1;
                spi_wr_data_o  = addr_q[8*ADDR_BYTES-1 -: 8];
                if (spi_wr_ready_i) begin
                    addr_step = 1'b1;
                    if (idx_q == 2'(ADDR_BYTES - 1))
                        state_d = data_st;
                    else
                        idx_d = idx_q + 2'd1;
                end
            end
            ST_WDATA: begin
                spi_en_o       = 1'b1;
                spi_wr_valid_o = wr_valid_i;
                spi_wr_data_o  = wr_data_i;
                wr_ready_o     = spi_wr_ready_i;
                if (wr_valid_i && spi_wr_ready_i) begin
                    rem_d = rem_q - CW'(1);
                    if (rem_q == CW'(1))
                        state_d = ST_END;
                end
            end
            ST_RDATA: begin
                spi_en_o       = 1'b1;
                spi_rd_ready_o = !buf_full || rd_ready_i;
                if (spi_rd_valid_i && done_cnt_q >= hdr)
                    buf_load = 1'b1;
                if (spi_rd_valid_i && spi_rd_ready_o && done_cnt_q == total_q - CW'(1))
                    state_d = ST_END;
            end
            ST_END: begin
                if (done_cnt_q == total_q && !buf_full && spi_csn_i) begin
`ifdef SPI_FLASH_WIP_POLL_EN
                    if (dir_q && !wip_q) begin
                        state_d    = ST_WIP_CMD;
                        done_cnt_d = '0;
                    end else begin
                        done_o  = 1'b1;
                        state_d = ST_IDLE;
                    end
`else
                    done_o  = 1'b1;
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef SPI_FLASH_WIP_POLL_EN
            ST_WIP_CMD: begin
                spi_en_o       = 1'b1;
                spi_wr_valid_o = 1'b1;
                spi_wr_data_o  = OP_RDSR;
                if (spi_wr_ready_i)
                    state_d = ST_WIP_READ;
            end
            ST_WIP_READ: begin
                spi_en_o       = 1'b1;
                spi_rd_ready_o = 1'b1;
                // The first pulse is the RDSR opcode byte itself.
                if (spi_rd_valid_i && done_cnt_q != '0 && !spi_rd_data_i[0]) begin
                    state_d = ST_END;
                    wip_d   = 1'b1;
                    total_d = done_cnt_q + CW'(1);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_IDLE;
            op_q       <= 8'h00;
            addr_q     <= '0;
            addr_en_q  <= 1'b0;
            dir_q      <= 1'b0;
            len_q      <= '0;
            total_q    <= '0;
            done_cnt_q <= '0;
            rem_q      <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            total_q    <= total_d;
            done_cnt_q <= done_cnt_d;
            rem_q      <= rem_d;
            idx_q      <= idx_d;
            if (accept) begin
                op_q      <= cmd_op_i;
                addr_q    <= cmd_addr_i;
                addr_en_q <= cmd_addr_en_i;
                dir_q     <= cmd_dir_i;
                len_q     <= cmd_len_i;
            end else if (addr_step) begin
                addr_q <= addr_q << 8;
            end
        end
    end

`ifdef SPI_FLASH_WIP_POLL_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) wip_q <= 1'b0;
        else         wip_q <= wip_d;
    end
`endif

    spi_flash_seq_rd_skid u_rd_skid (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .load      (buf_load),
        .in_data   (spi_rd_data_i),
        .out_ready (rd_ready_i),
        .out_valid (rd_valid_o),
        .out_data  (rd_data_o),
        .full      (buf_full)
    );

endmodule
